// File: rtl/microwave_ctrl_pkg.sv
// Shared definitions for the microwave oven control unit: state encoding,
// default timing constants and the keypad priority encoder.
package microwave_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int NUM_KEYS          = 10;
    localparam int TICK_DIV_DEFAULT  = 100;
    localparam int DONE_HOLD_DEFAULT = 300;

    // Lowest pressed key wins when several keys are down at once.
    function automatic logic [3:0] lowest_digit(input logic [NUM_KEYS-1:0] k);
        logic [3:0] result;
        result = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (k[i]) begin
                result = 4'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/microwave_ctrl_sec_prescaler.sv
// One-second prescaler: counts enabled cycles and emits a registered
// single-cycle tick each time TICK_DIV enabled cycles have elapsed.
module sec_prescaler
    import microwave_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int             W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    // A disabled prescaler keeps its value, so a paused cook resumes mid-second.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (enable) begin
                if (count == LAST) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Front-panel sequencer for the microwave oven: turns buttons, keypad and door
// into load/clear/tick strobes for the time datapath plus magnetron and done.
module microwave_ctrl
    import microwave_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int DONE_HOLD = DONE_HOLD_DEFAULT
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                startn,
    input  logic                stopn,
    input  logic                clearn,
    input  logic                door_closed,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                timer_zero,
    output logic                load_digit,
    output logic [3:0]          digit,
    output logic                timer_clear,
    output logic                count_tick,
    output logic                mag_on,
    output logic                done
);

    localparam int            HW        = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

    state_t                state;
    state_t                state_next;
    logic                  startn_q;
    logic [NUM_KEYS-1:0]   keys_q;
    logic [HW-1:0]         hold_count;
    logic [HW-1:0]         hold_next;

    logic start_ev;
    logic key_ev;
    logic stop_lvl;
    logic clr_lvl;
    logic door_open;
    logic load_next;
    logic clear_next;
    logic pre_clear;
    logic pre_enable;

    assign start_ev  = startn_q & ~startn;
    assign key_ev    = (keys != '0) && (keys_q == '0);
    assign stop_lvl  = ~stopn;
    assign clr_lvl   = ~clearn;
    assign door_open = ~door_closed;

    // The prescaler only advances on cycles that stay in COOK, so the exit and
    // resume edges do not count and a coincident timer_zero swallows the tick.
    assign pre_enable = (state == COOK) && (state_next == COOK);

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock  (clock),
        .resetn (resetn),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tick   (count_tick)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            hold_count <= '0;
            startn_q   <= 1'b1;
            keys_q     <= '0;
        end else begin
            state      <= state_next;
            hold_count <= hold_next;
            startn_q   <= startn;
            keys_q     <= keys;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = '0;
        load_next  = 1'b0;
        clear_next = 1'b0;
        pre_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_lvl || stop_lvl) begin
                    clear_next = 1'b1;
                end else if (key_ev) begin
                    load_next  = 1'b1;
                    state_next = SET;
                end
            end
            SET: begin
                if (clr_lvl || stop_lvl) begin
                    clear_next = 1'b1;
                    state_next = IDLE;
                end else if (start_ev && !door_open && !timer_zero) begin
                    pre_clear  = 1'b1;
                    state_next = COOK;
                end else if (key_ev) begin
                    load_next = 1'b1;
                end
            end
            COOK: begin
                if (door_open) begin
                    state_next = PAUSE;
                end else if (clr_lvl) begin
                    clear_next = 1'b1;
                    state_next = IDLE;
                end else if (stop_lvl) begin
                    state_next = PAUSE;
                end else if (timer_zero) begin
                    state_next = DONE;
                end
            end
            PAUSE: begin
                if (clr_lvl || stop_lvl) begin
                    clear_next = 1'b1;
                    state_next = IDLE;
                end else if (start_ev && !door_open && !timer_zero) begin
                    state_next = COOK;
                end
            end
            DONE: begin
                // Time is already zero here, so leaving never needs a clear.
                if (door_open || clr_lvl || stop_lvl || key_ev) begin
                    state_next = IDLE;
                end else if (hold_count == HOLD_LAST) begin
                    state_next = IDLE;
                end else begin
                    hold_next = hold_count + HW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            load_digit  <= 1'b0;
            digit       <= 4'd0;
            timer_clear <= 1'b0;
            mag_on      <= 1'b0;
            done        <= 1'b0;
        end else begin
            load_digit  <= load_next;
            timer_clear <= clear_next;
            mag_on      <= (state_next == COOK);
            done        <= (state_next == DONE);
            if (load_next) begin
                digit <= lowest_digit(keys);
            end
        end
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed bench for microwave_ctrl with a behavioural time-register model
// standing in for the countdown datapath.
module tb_microwave_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [9:0] keys;
    logic       timer_zero;
    logic       load_digit;
    logic [3:0] digit;
    logic       timer_clear;
    logic       count_tick;
    logic       mag_on;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int time_sec = 0;
    logic tz_force = 1'b0;

    int load_cnt = 0;
    int clear_cnt = 0;
    int tick_cnt = 0;
    int last_tick_cyc = -1;
    int mag_rise_cyc = -1;
    int mag_fall_cyc = -1;
    int done_rise_cyc = -1;
    int done_fall_cyc = -1;
    logic mag_prev = 1'b0;
    logic done_prev = 1'b0;
    logic [3:0] digits[$];

    microwave_ctrl dut (
        .clock       (clock),
        .resetn      (resetn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .keys        (keys),
        .timer_zero  (timer_zero),
        .load_digit  (load_digit),
        .digit       (digit),
        .timer_clear (timer_clear),
        .count_tick  (count_tick),
        .mag_on      (mag_on),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Countdown datapath stand-in: timer_zero follows a tick within one cycle.
    always @(posedge clock or negedge resetn) begin
        if (!resetn)                          time_sec <= 0;
        else if (timer_clear)                 time_sec <= 0;
        else if (load_digit)                  time_sec <= time_sec * 10 + int'(digit);
        else if (count_tick && time_sec > 0)  time_sec <= time_sec - 1;
    end

    assign timer_zero = tz_force || (time_sec == 0);

    always @(negedge clock) begin
        if (load_digit) begin
            load_cnt++;
            digits.push_back(digit);
        end
        if (timer_clear) clear_cnt++;
        if (count_tick) begin
            tick_cnt++;
            last_tick_cyc = cyc;
        end
        if (mag_on && !mag_prev) mag_rise_cyc = cyc;
        if (!mag_on && mag_prev) mag_fall_cyc = cyc;
        if (done && !done_prev) done_rise_cyc = cyc;
        if (!done && done_prev) done_fall_cyc = cyc;
        mag_prev  = mag_on;
        done_prev = done;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic press_key(input int k);
        keys = 10'b1 << k;
        cycles(50);
        keys = '0;
        cycles(150);
    endtask

    task automatic wait_tick(input int prev, input int limit, input string tag);
        int n;
        n = 0;
        while (tick_cnt == prev && n < limit) begin
            cycles(1);
            n++;
        end
        check_output(tag, 32'(tick_cnt != prev), 1);
    endtask

    initial begin
        int s;
        int r;
        int c0;
        int t0;
        int l0;
        int n;

        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; keys = '0;
        cycles(3);
        check_output("rst_load_digit", load_digit, 0);
        check_output("rst_digit", digit, 0);
        check_output("rst_timer_clear", timer_clear, 0);
        check_output("rst_count_tick", count_tick, 0);
        check_output("rst_mag_on", mag_on, 0);
        check_output("rst_done", done, 0);
        resetn = 1'b1;
        cycles(5);
        check_output("post_rst_state", dut.state, 0);
        check_output("post_rst_no_load", load_cnt, 0);
        check_output("post_rst_no_clear", clear_cnt, 0);

        $display("[TB] key entry 2,0,0 then start");
        press_key(2);
        press_key(0);
        press_key(0);
        check_output("entry_load_count", load_cnt, 3);
        check_output("entry_digit0", digits[0], 2);
        check_output("entry_digit1", digits[1], 0);
        check_output("entry_digit2", digits[2], 0);
        check_output("entry_state_set", dut.state, 1);
        s = cyc; startn = 1'b0; cycles(3); startn = 1'b1;
        check_output("start_mag_rise", mag_rise_cyc, s + 1);
        check_output("start_mag_on", mag_on, 1);
        t0 = tick_cnt;
        wait_tick(t0, 200, "first_tick_seen");
        check_output("first_tick_latency", last_tick_cyc, s + 101);

        $display("[TB] clear during cook");
        c0 = clear_cnt; clearn = 1'b0; cycles(1); clearn = 1'b1; cycles(3);
        check_output("cook_clear_pulses", clear_cnt - c0, 1);
        check_output("cook_clear_mag", mag_on, 0);
        check_output("cook_clear_state", dut.state, 0);

        $display("[TB] cook from 0:02 to done");
        press_key(2);
        s = cyc; startn = 1'b0; cycles(3); startn = 1'b1;
        t0 = tick_cnt;
        wait_tick(t0, 200, "t2_tick1_seen");
        check_output("t2_tick1_cycle", last_tick_cyc, s + 101);
        wait_tick(t0 + 1, 200, "t2_tick2_seen");
        check_output("t2_tick2_cycle", last_tick_cyc, s + 201);
        n = 0;
        while (!done && n < 20) begin cycles(1); n++; end
        check_output("done_seen", done, 1);
        check_output("done_rise_cycle", done_rise_cyc, s + 203);
        check_output("done_mag_fall_cycle", mag_fall_cyc, s + 203);
        n = 0;
        while (done && n < 400) begin cycles(1); n++; end
        check_output("done_dropped", done, 0);
        check_output("done_fall_cycle", done_fall_cyc, s + 503);
        check_output("done_tick_total", tick_cnt - t0, 2);
        check_output("done_state_idle", dut.state, 0);

        $display("[TB] door opened mid-second");
        press_key(5);
        s = cyc; startn = 1'b0; cycles(1); startn = 1'b1;
        cycles(40);
        door_closed = 1'b0;
        cycles(3);
        check_output("door_mag_fall_cycle", mag_fall_cyc, s + 42);
        check_output("door_state_pause", dut.state, 3);
        t0 = tick_cnt;
        startn = 1'b0; cycles(2); startn = 1'b1; cycles(5);
        check_output("door_open_start_mag", mag_on, 0);
        check_output("door_open_start_state", dut.state, 3);
        door_closed = 1'b1;
        cycles(10);
        check_output("pause_no_tick", tick_cnt - t0, 0);
        r = cyc; startn = 1'b0; cycles(1); startn = 1'b1;
        check_output("resume_mag_on", mag_on, 1);
        wait_tick(t0, 200, "resume_tick_seen");
        check_output("resume_tick_cycle", last_tick_cyc, r + 61);

        $display("[TB] stop to pause, then clear in pause");
        c0 = clear_cnt;
        stopn = 1'b0; cycles(1); stopn = 1'b1; cycles(3);
        check_output("stop_mag_off", mag_on, 0);
        check_output("stop_state_pause", dut.state, 3);
        clearn = 1'b0; cycles(1); clearn = 1'b1; cycles(3);
        check_output("pause_clear_pulses", clear_cnt - c0, 1);
        check_output("pause_clear_state", dut.state, 0);

        $display("[TB] simultaneous keys and start with timer at zero");
        l0 = load_cnt;
        keys = 10'b0000100100; cycles(50); keys = '0; cycles(20);
        check_output("multi_key_loads", load_cnt - l0, 1);
        check_output("multi_key_digit", digit, 2);
        tz_force = 1'b1;
        startn = 1'b0; cycles(2); startn = 1'b1; cycles(5);
        check_output("tz_start_mag", mag_on, 0);
        check_output("tz_start_state", dut.state, 1);
        tz_force = 1'b0;
        cycles(2);

        $display("[TB] start and stop together in set");
        c0 = clear_cnt;
        startn = 1'b0; stopn = 1'b0; cycles(1); startn = 1'b1; stopn = 1'b1; cycles(3);
        check_output("start_stop_clear", clear_cnt - c0, 1);
        check_output("start_stop_state", dut.state, 0);
        check_output("start_stop_mag", mag_on, 0);

        $display("[TB] reset while cooking");
        press_key(3);
        startn = 1'b0; cycles(2); startn = 1'b1; cycles(5);
        check_output("pre_reset_mag", mag_on, 1);
        #2 resetn = 1'b0;
        #1;
        check_output("async_reset_mag", mag_on, 0);
        check_output("async_reset_state", dut.state, 0);
        cycles(2);
        resetn = 1'b1;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
